// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue: word/address types,
// fetch FSM state encodings and the {pc, inst} queue entry layout.
package inst_fetch_queue_pkg;

  typedef logic [31:0] INS_TYPE;
  typedef logic [31:0] ADDR_TYPE;

  localparam INS_TYPE  ZERO_WORD  = 32'h0000_0000;
  localparam ADDR_TYPE ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic     TRUE       = 1'b1;
  localparam logic     FALSE      = 1'b0;

  typedef enum logic [1:0] {
    IQS_IDLE = 2'd0,
    IQS_REQ  = 2'd1,
    IQS_WAIT = 2'd2,
    IQS_DROP = 2'd3
  } iq_state_e;

  typedef struct packed {
    ADDR_TYPE pc;
    INS_TYPE  inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Circular buffer of {pc, inst} entries with push/pop/clear and a combinational
// head read that returns zeros while the queue is empty.
module iq_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  iq_entry_t                  push_data_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       valid_o,
  output iq_entry_t                  head_o
);

  localparam int AW = $clog2(DEPTH);

  iq_entry_t      mem_q [DEPTH];
  logic [AW-1:0]  head_q;
  logic [AW-1:0]  tail_q;
  logic [AW:0]    count_q;
  logic [AW:0]    count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push_i) tail_q <= tail_q + 1'b1;
        if (pop_i)  head_q <= head_q + 1'b1;
        count_q <= count_d;
      end
    end
  end

  // Storage carries no reset; only the pointers and count define what is live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && en_i && !clr_i && push_i) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[head_q] : iq_entry_t'({ZERO_WORD, ZERO_WORD});

endmodule

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetcher: one outstanding word request at a time, results
// buffered in iq_fifo; a jump flushes the queue and orphans any in-flight response.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int       IQ_DEPTH = 16,
  parameter ADDR_TYPE RESET_PC = 32'h0000_0000
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  output logic     mc_req_valid,
  output ADDR_TYPE mc_req_addr,
  input  logic     mc_req_ready,
  input  logic     mc_resp_valid,
  input  INS_TYPE  mc_resp_data,
  input  logic     jump_valid,
  input  ADDR_TYPE jump_pc,
  output logic     iq_valid,
  output INS_TYPE  iq_inst,
  output ADDR_TYPE iq_pc,
  input  logic     iq_pop
);

  localparam int              CW      = $clog2(IQ_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(IQ_DEPTH);

  iq_state_e       state_q;
  ADDR_TYPE        fetch_pc_q;
  logic            req_valid_q;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after_push_d;
  logic            push;
  logic            pop_eff;
  iq_entry_t       head;

  assign pop_eff            = iq_pop && iq_valid && !jump_valid;
  assign push               = (state_q == IQS_WAIT) && mc_resp_valid && !jump_valid;
  assign count_after_push_d = pop_eff ? count : count + 1'b1;

  // A request is only issued while a slot is free, so a push never meets a full queue.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IQS_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= FALSE;
    end else if (rdy_in) begin
      if (jump_valid) begin
        fetch_pc_q  <= jump_pc & ALIGN_MASK;
        req_valid_q <= FALSE;
        if (state_q == IQS_IDLE || (state_q == IQS_REQ && !mc_req_ready)) begin
          state_q <= IQS_IDLE;
        end else begin
          state_q <= IQS_DROP;
        end
      end else begin
        case (state_q)
          IQS_IDLE: begin
            if (count < DEPTH_C) begin
              state_q     <= IQS_REQ;
              req_valid_q <= TRUE;
            end
          end
          IQS_REQ: begin
            if (mc_req_ready) begin
              state_q     <= IQS_WAIT;
              req_valid_q <= FALSE;
            end
          end
          IQS_WAIT: begin
            if (mc_resp_valid) begin
              fetch_pc_q <= fetch_pc_q + 32'd4;
              if (count_after_push_d < DEPTH_C) begin
                state_q     <= IQS_REQ;
                req_valid_q <= TRUE;
              end else begin
                state_q <= IQS_IDLE;
              end
            end
          end
          IQS_DROP: begin
            if (mc_resp_valid) state_q <= IQS_IDLE;
          end
          default: begin
            state_q     <= IQS_IDLE;
            req_valid_q <= FALSE;
          end
        endcase
      end
    end
  end

  iq_fifo #(
    .DEPTH (IQ_DEPTH)
  ) u_fifo (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .en_i        (rdy_in),
    .clr_i       (jump_valid),
    .push_i      (push),
    .push_data_i ({fetch_pc_q, mc_resp_data}),
    .pop_i       (pop_eff),
    .count_o     (count),
    .valid_o     (iq_valid),
    .head_o      (head)
  );

  assign mc_req_valid = req_valid_q;
  assign mc_req_addr  = fetch_pc_q;
  assign iq_inst      = head.inst;
  assign iq_pc        = head.pc;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a latency-configurable memory model and a
// {pc, inst} scoreboard filled on accepted responses and drained on pops.
module tb_inst_fetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        mc_req_valid;
  logic [31:0] mc_req_addr;
  logic        mc_req_ready;
  logic        mc_resp_valid;
  logic [31:0] mc_resp_data;
  logic        jump_valid;
  logic [31:0] jump_pc;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_pop;

  always #5 clk_in = ~clk_in;

  inst_fetch_queue #(
    .IQ_DEPTH (16),
    .RESET_PC (32'h0)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .mc_req_valid  (mc_req_valid),
    .mc_req_addr   (mc_req_addr),
    .mc_req_ready  (mc_req_ready),
    .mc_resp_valid (mc_resp_valid),
    .mc_resp_data  (mc_resp_data),
    .jump_valid    (jump_valid),
    .jump_pc       (jump_pc),
    .iq_valid      (iq_valid),
    .iq_inst       (iq_inst),
    .iq_pc         (iq_pc),
    .iq_pop        (iq_pop)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb [$];
  logic [31:0] exp_pc;
  bit          inflight, orphan;
  bit          mem_busy, mem_const, force_resp;
  int          mem_cnt, lat;
  logic [31:0] mem_addr;
  bit          ready_en, pop_req, jump_req;
  logic [31:0] jump_target;
  int          hs_count, both_count;
  logic [31:0] last_hs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive at the negedge, update the model, then check outputs at the next negedge.
  task automatic tick();
    bit          resp_now, hs_now, pop_now, pushed;
    logic [31:0] rdata;
    resp_now      = (force_resp || (mem_busy && mem_cnt <= 0)) && rdy_in;
    rdata         = mem_const ? 32'h0000_0013 : (mem_addr ^ 32'hC0DE_0000);
    mc_resp_valid = resp_now;
    mc_resp_data  = resp_now ? rdata : 32'h0;
    mc_req_ready  = ready_en;
    jump_valid    = jump_req;
    jump_pc       = jump_target;
    iq_pop        = pop_req;
    #1;
    hs_now  = rdy_in && mc_req_valid && mc_req_ready;
    pop_now = rdy_in && pop_req && iq_valid && !jump_req;
    pushed  = 1'b0;
    if (rdy_in) begin
      if (pop_now && sb.size() > 0) begin
        chk("pop_pc", iq_pc, sb[0][63:32]);
        chk("pop_inst", iq_inst, sb[0][31:0]);
        void'(sb.pop_front());
      end
      if (resp_now) mem_busy = 1'b0;
      if (jump_req) begin
        if (hs_now) begin
          inflight = 1'b1;
          orphan   = 1'b1;
        end else if (inflight) begin
          orphan = 1'b1;
        end
      end else begin
        if (resp_now && inflight) begin
          if (!orphan) begin
            sb.push_back({exp_pc, rdata});
            exp_pc = exp_pc + 32'd4;
            pushed = 1'b1;
          end
          inflight = 1'b0;
          orphan   = 1'b0;
        end
        if (hs_now) inflight = 1'b1;
      end
      if (hs_now) begin
        chk("req_addr", mc_req_addr, jump_req ? exp_pc : exp_pc);
        mem_busy     = 1'b1;
        mem_cnt      = lat;
        mem_addr     = mc_req_addr;
        last_hs_addr = mc_req_addr;
        hs_count++;
      end
      if (pushed && pop_now) both_count++;
      if (jump_req) begin
        sb.delete();
        exp_pc = jump_target & 32'hFFFF_FFFC;
      end
    end
    @(negedge clk_in);
    if (mem_busy && mem_cnt > 0) mem_cnt--;
    jump_req   = 1'b0;
    force_resp = 1'b0;
    chk("iq_valid", {31'b0, iq_valid}, {31'b0, sb.size() != 0});
    if (sb.size() > 0) begin
      chk("head_pc", iq_pc, sb[0][63:32]);
      chk("head_inst", iq_inst, sb[0][31:0]);
    end else begin
      chk("empty_pc", iq_pc, 32'h0);
      chk("empty_inst", iq_inst, 32'h0);
    end
    $display("t=%0t hs=%0b resp=%0b pop=%0b sb=%0d iq_pc=%h", $time, hs_now, resp_now, pop_now, sb.size(), iq_pc);
  endtask

  task automatic wait_hs(input string tag);
    int start = hs_count;
    for (int i = 0; i < 100 && hs_count == start; i++) tick();
    chk(tag, {31'b0, hs_count != start}, 32'd1);
  endtask

  task automatic wait_req_valid(input string tag);
    for (int i = 0; i < 100 && !mc_req_valid; i++) tick();
    chk(tag, {31'b0, mc_req_valid}, 32'd1);
  endtask

  initial begin
    int hs_before;
    rst_in = 1'b1; rdy_in = 1'b1; mc_req_ready = 1'b0; mc_resp_valid = 1'b0;
    mc_resp_data = 32'h0; jump_valid = 1'b0; jump_pc = 32'h0; iq_pop = 1'b0;
    exp_pc = 32'h0; inflight = 0; orphan = 0; mem_busy = 0; mem_const = 1; force_resp = 0;
    mem_cnt = 0; lat = 1; mem_addr = 32'h0; ready_en = 0; pop_req = 0; jump_req = 0;
    jump_target = 32'h0; hs_count = 0; both_count = 0; last_hs_addr = 32'h0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    chk("rst_req_valid", {31'b0, mc_req_valid}, 32'd0);
    chk("rst_req_addr", mc_req_addr, 32'h0);
    chk("rst_iq_valid", {31'b0, iq_valid}, 32'd0);
    chk("rst_iq_inst", iq_inst, 32'h0);
    chk("rst_iq_pc", iq_pc, 32'h0);

    // 1: fill the queue with no pops
    ready_en = 1'b1;
    repeat (80) tick();
    chk("t1_hs_count", 32'(hs_count), 32'd16);
    chk("t1_last_addr", last_hs_addr, 32'h3C);
    chk("t1_req_valid", {31'b0, mc_req_valid}, 32'd0);
    chk("t1_iq_valid", {31'b0, iq_valid}, 32'd1);

    // 2: one pop from full -> exactly one refill at 0x40
    pop_req = 1'b1; tick(); pop_req = 1'b0;
    wait_hs("t2_hs");
    chk("t2_addr", last_hs_addr, 32'h40);
    repeat (6) tick();
    chk("t2_hs_count", 32'(hs_count), 32'd17);
    chk("t2_req_valid", {31'b0, mc_req_valid}, 32'd0);

    // 3: flush while WAIT, orphaned response dropped
    mem_const = 1'b0; lat = 3;
    pop_req = 1'b1; tick(); pop_req = 1'b0;
    wait_hs("t3_hs");
    tick();
    jump_req = 1'b1; jump_target = 32'h1003;
    tick();
    chk("t3_flush_valid", {31'b0, iq_valid}, 32'd0);
    chk("t3_flush_req", {31'b0, mc_req_valid}, 32'd0);
    wait_hs("t3_hs2");
    chk("t3_addr", last_hs_addr, 32'h1000);
    lat = 1;
    repeat (6) tick();
    chk("t3_first_pc", iq_pc, 32'h1000);

    // 4: flush coinciding with response and pop -> DROP
    wait_hs("t4_hs");
    jump_req = 1'b1; jump_target = 32'h2000; pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    chk("t4_iq_valid", {31'b0, iq_valid}, 32'd0);
    hs_before = hs_count;
    repeat (3) tick();
    chk("t4_drop_req", {31'b0, mc_req_valid}, 32'd0);
    chk("t4_drop_hs", 32'(hs_count), 32'(hs_before));
    force_resp = 1'b1;
    tick();
    wait_hs("t4_resume");
    chk("t4_addr", last_hs_addr, 32'h2000);
    // flush in REQ with ready low -> IDLE, re-request two cycles later
    ready_en = 1'b0;
    wait_req_valid("t4_wait_req");
    jump_req = 1'b1; jump_target = 32'h3008;
    tick();
    chk("t4_req_idle", {31'b0, mc_req_valid}, 32'd0);
    tick();
    chk("t4_req_again", {31'b0, mc_req_valid}, 32'd1);
    chk("t4_req_addr", mc_req_addr, 32'h3008);

    // 5: freeze mid-WAIT with pops held high
    ready_en = 1'b1;
    repeat (8) tick();
    lat = 3;
    wait_hs("t5_hs");
    tick();
    hs_before = hs_count;
    rdy_in = 1'b0; pop_req = 1'b1;
    repeat (5) begin
      tick();
      chk("t5_freeze_req", {31'b0, mc_req_valid}, 32'd0);
    end
    chk("t5_freeze_hs", 32'(hs_count), 32'(hs_before));
    rdy_in = 1'b1; pop_req = 1'b0; lat = 1;
    repeat (6) tick();
    chk("t5_resume_hs", {31'b0, hs_count > hs_before}, 32'd1);

    // 6: PC wrap and simultaneous push/pop
    ready_en = 1'b0;
    wait_req_valid("t6_wait_req");
    jump_req = 1'b1; jump_target = 32'hFFFF_FFFE;
    tick();
    tick();
    ready_en = 1'b1;
    wait_hs("t6_hs1");
    chk("t6_addr_top", last_hs_addr, 32'hFFFF_FFFC);
    wait_hs("t6_hs2");
    chk("t6_addr_wrap", last_hs_addr, 32'h0);
    repeat (6) tick();
    pop_req = 1'b1;
    repeat (10) tick();
    chk("t6_push_pop_seen", {31'b0, both_count > 0}, 32'd1);

    // drain everything that remains
    ready_en = 1'b0;
    for (int i = 0; i < 60 && (iq_valid || inflight); i++) tick();
    pop_req = 1'b0;
    chk("drain_iq_valid", {31'b0, iq_valid}, 32'd0);
    chk("drain_sb", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

endmodule
